mc_stall_ctrl: RTL and testbench
================================

MC_STALL_CTRL -- requirements
Module: mc_stall_ctrl

Interface
REQ-001 Parameter LAT_W, default 4: width of latency input and internal countdown.
REQ-002 Parameter MAX_LAT, default 7: largest honoured latency; 1 <= MAX_LAT <= 2^LAT_W-1.
REQ-003 Parameter TAG_W, default 4: width of op tag carried to completion.
REQ-004 Parameter STAT_W, default 16: width of saturating stall-cycle counter.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 issue  input  1  EX stage holds a valid op for this unit; held high while stalled.
REQ-008 latency  input  LAT_W  extra cycles op needs; 0 = single-cycle op.
REQ-009 tag  input  TAG_W  op identifier, sampled at acceptance.
REQ-010 flush  input  1  synchronous abort of in-flight op.
REQ-011 clr_stats  input  1  synchronous clear of stall_cycles.
REQ-012 stall  output  1  freeze upstream pipeline this cycle.
REQ-013 done  output  1  result valid this cycle; one pulse per accepted op.
REQ-014 done_tag  output  TAG_W  tag of completing op, valid when done=1.
REQ-015 remaining  output  LAT_W  stall cycles left after current cycle; 0 when idle.
REQ-016 lat_err  output  1  one-cycle pulse: accepted latency exceeded MAX_LAT.
REQ-017 stall_cycles  output  STAT_W  count of cycles with stall=1, saturating.

Function
REQ-018 FSM states IDLE, COUNT, DONE; register cnt (LAT_W).
REQ-019 Acceptance: state=IDLE, issue=1, flush=0; eff_lat = min(latency, MAX_LAT).
REQ-020 Accept with eff_lat=0: stall=0, done=1, done_tag=tag (combinational), stay IDLE.
REQ-021 Accept with eff_lat=1: stall=1 this cycle, capture tag, next state DONE.
REQ-022 Accept with eff_lat>1: stall=1, capture tag, cnt<=eff_lat-1, next state COUNT.
REQ-023 COUNT: stall=1; cnt=1 -> DONE, else cnt<=cnt-1.
REQ-024 DONE: stall=0, done=1, done_tag=captured tag; next state IDLE unconditionally; issue in DONE is the same held op and is never re-accepted.
REQ-025 Net timing: op accepted cycle T with eff_lat=L>0 -> stall high T..T+L-1 exactly, done at T+L, new op acceptable from T+L+1.
REQ-026 remaining: IDLE 0 (or eff_lat-1 on accept cycle), COUNT cnt-1, DONE 0.
REQ-027 lat_err=1 in acceptance cycle iff latency>MAX_LAT; op proceeds with MAX_LAT.
REQ-028 flush=1: stall=0, done=0, lat_err=0 that cycle; no acceptance; next state IDLE, cnt 0.
REQ-029 stall_cycles increments by 1 each cycle stall=1, holds at 2^STAT_W-1.
REQ-030 clr_stats takes priority over increment: stall_cycles<=0.
REQ-031 issue=0 in COUNT does not abort; countdown continues (only flush/rst abort).
REQ-032 All outputs free of X when inputs are known.

Reset
REQ-033 rst=1 asynchronously forces IDLE, cnt=0, captured tag=0, stall_cycles=0.
REQ-034 While rst=1: stall=0, done=0, lat_err=0, remaining=0, done_tag=0 regardless of issue.
REQ-035 Deassertion mid-op: nothing resumes; first accept possible on first edge after rst low.

Verification
REQ-036 issue=1, latency=0, tag=5 in IDLE -> stall=0, done=1, done_tag=5 same cycle; stall_cycles unchanged.
REQ-037 issue held, latency=3, tag=9 at cycle 0 -> stall=1 cycles 0-2, remaining 2,1,0; done=1, done_tag=9 cycle 3; stall_cycles=3; no second done cycle 4 with issue low.
REQ-038 latency=12, MAX_LAT=7 -> lat_err pulse cycle 0, stall cycles 0-6, done cycle 7.
REQ-039 latency=6 accepted, flush=1 at cycle 2 -> stall=0 cycle 2, state IDLE cycle 3, no done ever; new latency=1 op at cycle 3 -> done cycle 4.
REQ-040 STAT_W=4, 20 stalled cycles -> stall_cycles saturates at 15; clr_stats concurrent with stall -> 0.
REQ-041 rst asserted mid-COUNT (latency=5, cycle 2) -> stall, remaining to 0 immediately; after release, issue latency=2 -> done 2 cycles later.

Source files
------------

// File: rtl/mc_stall_ctrl.sv
// Multi-cycle execution-unit stall controller: freezes the upstream pipeline for
// the op's extra latency, then pulses done with the captured tag.
//
// state | meaning
// IDLE  | no op in flight; accepts a new op (single-cycle ops complete here)
// COUNT | op in flight, stall asserted while cnt counts down
// DONE  | result valid, stall released; back to IDLE next cycle
module mc_stall_ctrl #(
    parameter int LAT_W   = 4,
    parameter int MAX_LAT = 7,
    parameter int TAG_W   = 4,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [LAT_W-1:0]  latency,
    input  logic [TAG_W-1:0]  tag,
    input  logic              flush,
    input  logic              clr_stats,
    output logic              stall,
    output logic              done,
    output logic [TAG_W-1:0]  done_tag,
    output logic [LAT_W-1:0]  remaining,
    output logic              lat_err,
    output logic [STAT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    localparam logic [LAT_W-1:0]  MAX_L    = LAT_W'(MAX_LAT);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    state_t            state;
    logic [LAT_W-1:0]  cnt;
    logic [TAG_W-1:0]  tag_q;
    logic [LAT_W-1:0]  eff_lat;
    logic              accept;
    logic              accept_zero;
    logic              accept_multi;

    assign eff_lat      = (latency > MAX_L) ? MAX_L : latency;
    assign accept       = !rst && !flush && issue && (state == IDLE);
    assign accept_zero  = accept && (eff_lat == '0);
    assign accept_multi = accept && (eff_lat != '0);

    // Outputs are qualified by rst and flush so an asserted reset or abort
    // silences the unit in the same cycle, whatever issue is doing.
    assign stall    = !rst && !flush && (accept_multi || (state == COUNT));
    assign done     = !rst && !flush && (accept_zero || (state == DONE));
    assign done_tag = !done ? '0 : ((state == DONE) ? tag_q : tag);
    assign lat_err  = accept && (latency > MAX_L);

    always_comb begin
        remaining = '0;
        if (!rst && !flush) begin
            if (accept_multi)
                remaining = eff_lat - 1'b1;
            else if (state == COUNT)
                remaining = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            tag_q <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_multi) begin
                        tag_q <= tag;
                        if (eff_lat == 1) begin
                            state <= DONE;
                        end else begin
                            cnt   <= eff_lat - 1'b1;
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (cnt == 1) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                // issue seen here is still the op that just completed
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (clr_stats)
            stall_cycles <= '0;
        else if (stall && (stall_cycles != STAT_MAX))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_mc_stall_ctrl.sv
// Bench for mc_stall_ctrl: expected completions are queued at issue and matched
// against done pulses; per-cycle stall/remaining/lat_err and stall statistics.
module tb_mc_stall_ctrl;

    localparam int LAT_W   = 4;
    localparam int MAX_LAT = 7;
    localparam int TAG_W   = 4;
    localparam int STAT_W  = 4;
    localparam int STAT_MX = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              issue = 1'b0;
    logic [LAT_W-1:0]  latency = '0;
    logic [TAG_W-1:0]  tag = '0;
    logic              flush = 1'b0;
    logic              clr_stats = 1'b0;
    logic              stall;
    logic              done;
    logic [TAG_W-1:0]  done_tag;
    logic [LAT_W-1:0]  remaining;
    logic              lat_err;
    logic [STAT_W-1:0] stall_cycles;

    typedef struct {
        int               cyc;
        logic [TAG_W-1:0] tg;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   exp_stats = 0;

    mc_stall_ctrl #(
        .LAT_W(LAT_W), .MAX_LAT(MAX_LAT), .TAG_W(TAG_W), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst(rst), .issue(issue), .latency(latency), .tag(tag),
        .flush(flush), .clr_stats(clr_stats), .stall(stall), .done(done),
        .done_tag(done_tag), .remaining(remaining), .lat_err(lat_err),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sample_done();
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 0);
            end else begin
                e = sb.pop_front();
                chk("done_cyc", cyc, e.cyc);
                chk("done_tag", 32'(done_tag), 32'(e.tg));
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic stats_edge(input logic stalled, input logic clr);
        if (clr)
            exp_stats = 0;
        else if (stalled && exp_stats < STAT_MX)
            exp_stats++;
    endtask

    // Issue one op, hold issue through its done cycle, check every cycle.
    task automatic run_op(input int lat, input int tg, input int clr_at);
        int l;
        l = (lat > MAX_LAT) ? MAX_LAT : lat;
        issue   = 1'b1;
        latency = LAT_W'(lat);
        tag     = TAG_W'(tg);
        sb.push_back('{cyc + l, TAG_W'(tg)});
        for (int k = 0; k <= l; k++) begin
            clr_stats = (k == clr_at);
            #1;
            sample_done();
            chk("stall", 32'(stall), (k < l) ? 1 : 0);
            chk("remaining", 32'(remaining), (k < l) ? (l - 1 - k) : 0);
            chk("lat_err", 32'(lat_err), (k == 0 && lat > MAX_LAT) ? 1 : 0);
            stats_edge(k < l, k == clr_at);
            next_cycle();
        end
        issue     = 1'b0;
        clr_stats = 1'b0;
        #1;
        chk("stall_cycles", 32'(stall_cycles), exp_stats);
    endtask

    task automatic idle_cycle();
        issue = 1'b0;
        #1;
        sample_done();
        chk("idle_done", 32'(done), 0);
        chk("idle_stall", 32'(stall), 0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state, with issue active to prove outputs are forced low
        issue = 1'b1; latency = 4'd3; tag = 4'd11;
        #2;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_lat_err", 32'(lat_err), 0);
        chk("rst_remaining", 32'(remaining), 0);
        chk("rst_done_tag", 32'(done_tag), 0);
        chk("rst_stats", 32'(stall_cycles), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue = 1'b0;

        run_op(0, 5, -1);      // single-cycle op, stats unchanged
        run_op(3, 9, -1);      // held issue, done at cycle 3
        idle_cycle();          // no second done with issue low
        run_op(12, 3, -1);     // clamped to MAX_LAT with lat_err

        // flush mid-op: no done ever, unit idle next cycle
        issue = 1'b1; latency = 4'd6; tag = 4'd2;
        for (int k = 0; k < 2; k++) begin
            #1;
            sample_done();
            chk("fl_stall", 32'(stall), 1);
            chk("fl_remaining", 32'(remaining), 5 - k);
            stats_edge(1'b1, 1'b0);
            next_cycle();
        end
        flush = 1'b1;
        #1;
        sample_done();
        chk("fl_cut_stall", 32'(stall), 0);
        chk("fl_cut_done", 32'(done), 0);
        chk("fl_cut_lat_err", 32'(lat_err), 0);
        next_cycle();
        flush = 1'b0;
        run_op(1, 7, -1);      // accepted right after the flush

        run_op(7, 1, -1);      // pushes stats past 15 -> saturates
        run_op(5, 8, -1);      // stays saturated
        run_op(4, 6, 1);       // clr_stats while stalled wins

        // asynchronous reset in the middle of a countdown
        issue = 1'b1; latency = 4'd5; tag = 4'd10;
        for (int k = 0; k < 2; k++) begin
            #1;
            sample_done();
            chk("ra_stall", 32'(stall), 1);
            next_cycle();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("ra_stall_rst", 32'(stall), 0);
        chk("ra_remaining_rst", 32'(remaining), 0);
        chk("ra_done_rst", 32'(done), 0);
        exp_stats = 0;
        chk("ra_stats_rst", 32'(stall_cycles), exp_stats);
        next_cycle();
        rst = 1'b0;
        issue = 1'b0;
        idle_cycle();          // aborted op must not resume
        run_op(2, 4, -1);

        idle_cycle();
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
